bin2bcd_seq: RTL

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_pkg.sv | 19 +
 rtl/bcd_add3.sv | 14 +
 rtl/bin2bcd_seq.sv | 113 +++++++++++
 3 files changed

// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg -- shared constants and FSM encoding for the sequential
// binary-to-BCD converter.
//   DEF_WIDTH  : default binary operand width
//   DEF_DIGITS : default BCD digit count (10^DIGITS >= 2^WIDTH)
//   BCD_W      : bits per BCD nibble
//   state_t    : converter FSM states
package bin2bcd_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_DIGITS = 5;
  localparam int BCD_W      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// bcd_add3 -- double-dabble digit correction: adds 3 to a BCD nibble that is
// 5 or more, so the following left shift carries correctly into the next digit.
//   i_nib : scratch digit before correction
//   o_nib : corrected digit
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [BCD_W-1:0] i_nib,
  output logic [BCD_W-1:0] o_nib
);

  assign o_nib = (i_nib >= BCD_W'(5)) ? i_nib + BCD_W'(3) : i_nib;

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq -- sequential shift-add-3 binary-to-BCD converter, one operand
// bit per clock.
//   clock    : rising-edge clock
//   reset    : asynchronous active-high reset
//   bin_in   : unsigned operand, latched on an accepted start
//   start    : conversion request, honoured only in IDLE
//   busy     : high in SHIFT and DONE
//   done     : one-cycle pulse when bcd_out/digit_on are refreshed
//   bcd_out  : packed BCD result, digit 0 in [3:0]
//   digit_on : leading-zero blanking mask, bit 0 always set
// DIGITS must satisfy 10^DIGITS >= 2^WIDTH; WIDTH must be at least 2.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      bin_in,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [BCD_W*DIGITS-1:0] bcd_out,
  output logic [DIGITS-1:0]     digit_on
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int SCR_W = BCD_W * DIGITS;

  state_t             r_state;
  logic [WIDTH-1:0]   r_op;
  logic [SCR_W-1:0]   r_scr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [SCR_W-1:0]   r_bcd;
  logic [DIGITS-1:0]  r_on;

  logic [SCR_W-1:0]   w_adj;
  logic [DIGITS-1:0]  w_on;

  // Per-digit +3 correction applied ahead of every shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_nib (r_scr[g*BCD_W +: BCD_W]),
      .o_nib (w_adj[g*BCD_W +: BCD_W])
    );
  end

  // Blanking mask: a digit lights if it or any more significant digit is
  // nonzero; the units digit always lights so zero shows as "0".
  always_comb begin
    logic w_any;
    w_any = 1'b0;
    w_on  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_any   = w_any | (|r_scr[i*BCD_W +: BCD_W]);
      w_on[i] = w_any;
    end
    w_on[0] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_scr   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bcd   <= '0;
      r_on    <= DIGITS'(1);
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op    <= bin_in;
            r_scr   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          // {scratch, operand} shifts left as one register after correction.
          r_scr <= {w_adj[SCR_W-2:0], r_op[WIDTH-1]};
          r_op  <= {r_op[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= DONE;
        end
        DONE: begin
          r_bcd   <= r_scr;
          r_on    <= w_on;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign bcd_out  = r_bcd;
  assign digit_on = r_on;

endmodule
